// File: rtl/placement_pkg.sv
// Shared definitions for the placement engine and its read-back checker.
//   - default grid side, edge count and data/address width
//   - UNPLACED marker stored in pos_X / pos_Y for nodes with no location
//   - checker state encoding
package placement_pkg;

    localparam int N_DEFAULT      = 6;
    localparam int N_EDGE_DEFAULT = 37;
    localparam int W_DEFAULT      = 32;

    localparam int UNPLACED = -1;

    // Every memory read is RD (strobe issued) -> WAIT -> CAP (data latched).
    typedef enum logic [4:0] {
        S_IDLE,
        S_E_RD,  S_E_WAIT,  S_E_CAP,
        S_PA_RD, S_PA_WAIT, S_PA_CAP,
        S_PB_RD, S_PB_WAIT, S_PB_CAP,
        S_CHK,
        S_GA_RD, S_GA_WAIT, S_GA_CAP,
        S_GB_RD, S_GB_WAIT, S_GB_CAP,
        S_ACC,
        S_NEXT,
        S_DONE
    } chk_state_t;

endpackage

// File: rtl/placement_checker_if.sv
// Read-only view of the placement memories (edge ROMs, position RAMs, grid).
//   master: the reader; drives strobes and addresses, receives read data
//   slave : the memory side
// Signals:
//   reE/addrE -> a_in, b_in   : ea/eb edge ROMs (shared index)
//   reP/addrP -> px_in, py_in : pos_X/pos_Y by node id (signed)
//   reG/addrG -> g_in         : grid cell x*N+y (signed node id)
interface placement_checker_if #(
    parameter int W = 32
) ();

    logic                reE;
    logic [W-1:0]        addrE;
    logic [W-1:0]        a_in;
    logic [W-1:0]        b_in;
    logic                reP;
    logic [W-1:0]        addrP;
    logic signed [W-1:0] px_in;
    logic signed [W-1:0] py_in;
    logic                reG;
    logic [W-1:0]        addrG;
    logic signed [W-1:0] g_in;

    modport master (
        output reE, addrE, reP, addrP, reG, addrG,
        input  a_in, b_in, px_in, py_in, g_in
    );

    modport slave (
        input  reE, addrE, reP, addrP, reG, addrG,
        output a_in, b_in, px_in, py_in, g_in
    );

endinterface

// File: rtl/hop_cost.sv
// Combinational edge cost unit.
//   ax, ay, bx, by : endpoint coordinates (signed)
//   dx, dy         : |ax-bx|, |ay-by| (two's-complement negate, wraps)
//   cost           : dx + dy - 1
//   cost_1hop      : ceil(dx/2) + ceil(dy/2) - 1
// Shared with the engine's evaluation path, which is why dx/dy are exposed.
module hop_cost #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] ax,
    input  logic signed [W-1:0] ay,
    input  logic signed [W-1:0] bx,
    input  logic signed [W-1:0] by,
    output logic [W-1:0]        dx,
    output logic [W-1:0]        dy,
    output logic signed [W-1:0] cost,
    output logic signed [W-1:0] cost_1hop
);

    localparam logic [W-1:0] ONE = W'(1);

    function automatic logic [W-1:0] abs_diff(input logic signed [W-1:0] p,
                                              input logic signed [W-1:0] q);
        logic signed [W-1:0] d;
        d = p - q;
        return d[W-1] ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic [W-1:0] ceil_half(input logic [W-1:0] v);
        return (v >> 1) + {{(W-1){1'b0}}, v[0]};
    endfunction

    assign dx        = abs_diff(ax, bx);
    assign dy        = abs_diff(ay, by);
    assign cost      = $signed(dx + dy - ONE);
    assign cost_1hop = $signed(ceil_half(dx) + ceil_half(dy) - ONE);

endmodule

// File: rtl/placement_checker.sv
// Read-back checker for a finished placement.
// Walks every edge (a,b), reads both endpoint positions and the grid cells
// they claim, and recomputes total wirelength and 1-hop cost. Never writes.
// Ports:
//   clk, reset (async, active-low)
//   start        : one-cycle pulse, begins a pass (ignored while busy)
//   busy, done   : pass in progress / one-cycle end-of-pass pulse
//   sum          : signed total of |dx|+|dy|-1 over fully placed edges
//   sum_1hop     : signed total of ceil(|dx|/2)+ceil(|dy|/2)-1
//   err_unplaced : sticky, an endpoint has X or Y == UNPLACED
//   err_range    : sticky, a coordinate lies outside [0,N-1] (and is not UNPLACED)
//   err_grid     : sticky, grid[x*N+y] differs from the node id
//   err_count    : number of edges with any error
//   mem          : memory read ports (strobe registered in cycle t, data
//                  sampled in cycle t+2)
module placement_checker
    import placement_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int N_EDGE = N_EDGE_DEFAULT,
    parameter int W      = W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] sum_1hop,
    output logic                err_unplaced,
    output logic                err_range,
    output logic                err_grid,
    output logic [W-1:0]        err_count,
    placement_checker_if.master mem
);

    localparam logic signed [W-1:0] UNPL_W   = W'(UNPLACED);
    localparam logic signed [W-1:0] N_W      = W'(N);
    localparam logic [W-1:0]        LAST_IDX = W'(N_EDGE - 1);

    chk_state_t state, state_nx;

    logic [W-1:0]        edge_idx;
    logic                edge_err;
    logic [W-1:0]        a_id, b_id;
    logic signed [W-1:0] ax, ay, bx, by;

    logic                a_unpl, b_unpl, a_rng, b_rng, both_ok;
    logic [W-1:0]        grid_a, grid_b;
    logic [W-1:0]        dx, dy;
    logic signed [W-1:0] cost, cost_1hop;
    logic                hop_unused;

    function automatic logic is_unplaced(input logic signed [W-1:0] x,
                                         input logic signed [W-1:0] y);
        return (x == UNPL_W) || (y == UNPL_W);
    endfunction

    function automatic logic out_of_range(input logic signed [W-1:0] c);
        return (c != UNPL_W) && (c[W-1] || (c >= N_W));
    endfunction

    assign a_unpl  = is_unplaced(ax, ay);
    assign b_unpl  = is_unplaced(bx, by);
    assign a_rng   = out_of_range(ax) || out_of_range(ay);
    assign b_rng   = out_of_range(bx) || out_of_range(by);
    assign both_ok = !(a_unpl || b_unpl || a_rng || b_rng);

    assign grid_a = ax * N_W + ay;
    assign grid_b = bx * N_W + by;

    hop_cost #(.W(W)) u_hop (
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .dx        (dx),
        .dy        (dy),
        .cost      (cost),
        .cost_1hop (cost_1hop)
    );

    // The checker only accumulates the costs; dx/dy serve the engine.
    assign hop_unused = ^{dx, dy};

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_E_RD;
            S_E_RD:    state_nx = S_E_WAIT;
            S_E_WAIT:  state_nx = S_E_CAP;
            S_E_CAP:   state_nx = S_PA_RD;
            S_PA_RD:   state_nx = S_PA_WAIT;
            S_PA_WAIT: state_nx = S_PA_CAP;
            S_PA_CAP:  state_nx = S_PB_RD;
            S_PB_RD:   state_nx = S_PB_WAIT;
            S_PB_WAIT: state_nx = S_PB_CAP;
            S_PB_CAP:  state_nx = S_CHK;
            S_CHK:     state_nx = both_ok ? S_GA_RD : S_NEXT;
            S_GA_RD:   state_nx = S_GA_WAIT;
            S_GA_WAIT: state_nx = S_GA_CAP;
            S_GA_CAP:  state_nx = S_GB_RD;
            S_GB_RD:   state_nx = S_GB_WAIT;
            S_GB_WAIT: state_nx = S_GB_CAP;
            S_GB_CAP:  state_nx = S_ACC;
            S_ACC:     state_nx = S_NEXT;
            S_NEXT:    state_nx = (edge_idx == LAST_IDX) ? S_DONE : S_E_RD;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Captured operands are only meaningful after their CAP state, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        case (state)
            S_E_CAP:  begin a_id <= mem.a_in;  b_id <= mem.b_in;  end
            S_PA_CAP: begin ax   <= mem.px_in; ay   <= mem.py_in; end
            S_PB_CAP: begin bx   <= mem.px_in; by   <= mem.py_in; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum          <= '0;
            sum_1hop     <= '0;
            err_unplaced <= 1'b0;
            err_range    <= 1'b0;
            err_grid     <= 1'b0;
            err_count    <= '0;
            edge_idx     <= '0;
            edge_err     <= 1'b0;
            mem.reE      <= 1'b0;
            mem.reP      <= 1'b0;
            mem.reG      <= 1'b0;
            mem.addrE    <= '0;
            mem.addrP    <= '0;
            mem.addrG    <= '0;
        end else begin
            mem.reE <= (state == S_E_RD);
            mem.reP <= (state == S_PA_RD) || (state == S_PB_RD);
            mem.reG <= (state == S_GA_RD) || (state == S_GB_RD);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sum          <= '0;
                        sum_1hop     <= '0;
                        err_unplaced <= 1'b0;
                        err_range    <= 1'b0;
                        err_grid     <= 1'b0;
                        err_count    <= '0;
                        edge_idx     <= '0;
                        edge_err     <= 1'b0;
                    end
                end
                S_E_RD:  mem.addrE <= edge_idx;
                S_PA_RD: mem.addrP <= a_id;
                S_PB_RD: mem.addrP <= b_id;
                S_CHK: begin
                    if (a_unpl || b_unpl) err_unplaced <= 1'b1;
                    if (a_rng || b_rng)   err_range    <= 1'b1;
                    if (!both_ok)         edge_err     <= 1'b1;
                end
                S_GA_RD: mem.addrG <= grid_a;
                S_GA_CAP: begin
                    if (mem.g_in != a_id) begin
                        err_grid <= 1'b1;
                        edge_err <= 1'b1;
                    end
                end
                S_GB_RD: mem.addrG <= grid_b;
                S_GB_CAP: begin
                    if (mem.g_in != b_id) begin
                        err_grid <= 1'b1;
                        edge_err <= 1'b1;
                    end
                end
                // A grid mismatch still contributes its cost.
                S_ACC: begin
                    sum      <= sum + cost;
                    sum_1hop <= sum_1hop + cost_1hop;
                end
                S_NEXT: begin
                    err_count <= err_count + {{(W-1){1'b0}}, edge_err};
                    edge_err  <= 1'b0;
                    edge_idx  <= edge_idx + W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/placement_checker.md
Name: placement_checker

Overview:
- Read-side companion to the placement engine: after placement finishes, walks the edge list and reads back pos_X, pos_Y and grid.
- Recomputes total Manhattan wirelength and 1-hop cost.
- Checks that every edge endpoint is placed, in range, and consistent with the grid.
- Sits beside the placement engine on the same memories, through their read ports only. It never writes.

Parameters:
- N, 6, grid side; grid address = x*N+y.
- N_EDGE, 37, number of edges in the ea/eb ROMs.
- W, 32, data and address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (clk and reset are the only clock/reset; polarity and asynchronous assertion are fixed)
- start  in  1  one-cycle pulse; begins a check pass
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of pass
- sum  out  W  signed total of (|dx|+|dy|-1)
- sum_1hop  out  W  signed total of (ceil(|dx|/2)+ceil(|dy|/2)-1)
- err_unplaced  out  1  sticky: some endpoint has X or Y = -1
- err_range  out  1  sticky: some coordinate is outside [0,N-1]
- err_grid  out  1  sticky: grid[x*N+y] differs from the node id
- err_count  out  W  number of edges with any error
- reE  out  1  read strobe for the ea/eb ROMs
- addrE  out  W  edge index, shared by ea and eb
- a_in, b_in  in  W  ea/eb read data
- reP  out  1  read strobe for pos_X/pos_Y
- addrP  out  W  node id
- px_in, py_in  in  W  pos_X/pos_Y read data (signed)
- reG  out  1  grid read strobe
- addrG  out  W  grid address
- g_in  in  W  grid read data (signed)

Behaviour:
- Memory timing: a strobe registered high in cycle t gives valid data sampled in cycle t+2. Each read goes through one WAIT state, giving the same spacing the placement engine uses.
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, all strobes 0, all addresses 0, internal edge counter 0. Reset in mid-pass aborts the pass and no done is issued.
- IDLE: start=1 clears sum, sum_1hop, err_*, err_count and sets edge index i=0; go to E_RD. busy rises the next cycle. start while busy is ignored.
- E_RD: reE=1, addrE=i -> WAIT -> E_CAP: latch a, b.
- PA_RD: reP=1, addrP=a -> WAIT -> PA_CAP: latch ax, ay.
- PB_RD: reP=1, addrP=b -> WAIT -> PB_CAP: latch bx, by.
- CHK: classify each endpoint. Unplaced if X or Y == -1. Out of range if the coordinate is <0 or >=N and not -1. Flag err_unplaced / err_range accordingly.
  - If both endpoints are valid: go to GA_RD.
  - Otherwise: set edge_err and go to NEXT with no accumulation.
- GA_RD: reG=1, addrG=ax*N+ay -> WAIT -> GA_CAP: if g != a, set err_grid and edge_err.
- GB_RD: same for b.
- ACC:
  - dx = |ax-bx|, dy = |ay-by|, in two's-complement negate.
  - sum += dx+dy-1.
  - sum_1hop += (dx>>1)+dx[0] + (dy>>1)+dy[0] - 1.
  - Accumulation happens even if err_grid was set for this edge. Wrap-around is modulo 2^W.
- NEXT: if edge_err, err_count += 1; clear edge_err; i += 1.
  - If i == N_EDGE after increment: go to DONE.
  - Else: go to E_RD.
- DONE: done=1 for one cycle, busy=0, go to IDLE. Results and flags hold until the next accepted start.
- Self-loop edge (a == b): dx = dy = 0, contributes -1 to both sums. This matches the placement engine's evaluation.
- N_EDGE = 0 is not supported.
- Strobes are one cycle wide. Addresses are held stable until the next read.

Decomposition:
- Shared package placement_pkg:
  - state encoding constants
  - UNPLACED = -1
  - default N, N_EDGE, W (also consumed by the placement engine)
- One sub-module, hop_cost: combinational/registered cost unit. Takes (ax, ay, bx, by) and produces dx, dy, cost and cost_1hop. It is used in ACC and is reusable by the engine's eval path.

Test Plan:
- 2 edges (0-1, 1-2), nodes at (0,0), (2,3), (5,5), grid consistent, N=6 -> sum = 4+4 = 8, sum_1hop = 2+2 = 4, all err = 0, err_count = 0, done pulses once.
- Node 1 has pos_X = -1 on the same edge list -> err_unplaced = 1, err_count = 2, both edges skipped, sum = 0.
- Node 2 at (6,0) -> err_range = 1, err_count = 1, sum = 4 (edge 0-1 only).
- grid[2*6+3] = 7 instead of 1 -> err_grid = 1, err_count = 2, sum still 8.
- Assert reset low during PB_RD of edge 1 -> all outputs 0 asynchronously, no done. A new start gives the same result as a clean run.
- start pulse while busy -> ignored: single done, values identical to a single pass. Results hold after DONE until the next start.
